// File: rtl/pe_sequencer_if.sv
// Bundles the command, operand, PE and result channels of the PE sequencer.
// slave = the sequencer itself; master = whoever drives commands and operands
// and models the PE.
`ifndef PE_SEQ_DEFS
`define PE_SEQ_DEFS
`define PE_MODE_BITWIDTH   2
`define PE_VALUE_BITWIDTH  5
`define PE_INPUT_BITWIDTH  32
`define PE_OUTPUT_BITWIDTH 32
`define PE_RND_OPCODE      (1'b1)
`define PE_CLR_VALUE       (5'd0)
`define PE_MAC_VALUE       (5'd1)
`define PE_OUT_VALUE       (5'd2)
`endif

interface pe_sequencer_if #(
  parameter int LEN_BITWIDTH = 16
);
  typedef struct packed {
    logic                          opcode;
    logic [`PE_VALUE_BITWIDTH-1:0] value;
    logic [`PE_MODE_BITWIDTH-1:0]  mode;
  } pe_inst_t;

  logic                           cmd_valid, cmd_ready;
  logic [`PE_MODE_BITWIDTH-1:0]   cmd_mode;
  logic [LEN_BITWIDTH-1:0]        cmd_len;
  logic [`PE_VALUE_BITWIDTH-1:0]  cmd_shift;
  logic                           op_valid, op_ready;
  logic [`PE_INPUT_BITWIDTH-1:0]  op_vector, op_matrix;
  pe_inst_t                       pe_inst;
  logic                           pe_inst_valid;
  logic [`PE_INPUT_BITWIDTH-1:0]  pe_vector, pe_matrix;
  logic [`PE_OUTPUT_BITWIDTH-1:0] pe_result;
  logic                           res_valid, res_ready;
  logic [`PE_OUTPUT_BITWIDTH-1:0] res_data;
  logic                           busy;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, cmd_shift,
    input  op_valid, op_vector, op_matrix, pe_result, res_ready,
    output cmd_ready, op_ready, pe_inst, pe_inst_valid, pe_vector, pe_matrix,
    output res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_len, cmd_shift,
    output op_valid, op_vector, op_matrix, pe_result, res_ready,
    input  cmd_ready, op_ready, pe_inst, pe_inst_valid, pe_vector, pe_matrix,
    input  res_valid, res_data, busy
  );
endinterface

// File: rtl/pe_sequencer.sv
// PE sequencer: turns one command into CLR, N MACs, RND, OUT instructions for
// a PE, feeds operands one cycle behind each MAC issue, waits out the PE
// pipeline and hands back the PE result.
`ifndef PE_SEQ_DEFS
`define PE_SEQ_DEFS
`define PE_MODE_BITWIDTH   2
`define PE_VALUE_BITWIDTH  5
`define PE_INPUT_BITWIDTH  32
`define PE_OUTPUT_BITWIDTH 32
`define PE_RND_OPCODE      (1'b1)
`define PE_CLR_VALUE       (5'd0)
`define PE_MAC_VALUE       (5'd1)
`define PE_OUT_VALUE       (5'd2)
`endif

module pe_sequencer #(
  parameter int LEN_BITWIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  pe_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, CLR, MAC, DRAIN0, DRAIN1, RND, OUT, WAIT0, WAIT1, RESP
  } state_t;

  state_t                        state;
  logic [`PE_MODE_BITWIDTH-1:0]  mode_q;
  logic [LEN_BITWIDTH-1:0]       len_q;
  logic [LEN_BITWIDTH-1:0]       cnt;
  logic [`PE_VALUE_BITWIDTH-1:0] shift_q;
  logic                          op_fire;
  logic                          last_mac;

  assign op_fire  = (state == MAC) && bus.op_valid;
  // len_q is nonzero whenever MAC is reachable, so len_q-1 never underflows
  // and the full-width compare lets N = 2^LEN_BITWIDTH-1 finish without wrap.
  assign last_mac = (cnt == len_q - LEN_BITWIDTH'(1));

  // Command sequencing FSM; also latches the command and captures the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_q       <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      cnt          <= '0;
      bus.res_data <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          mode_q  <= bus.cmd_mode;
          len_q   <= bus.cmd_len;
          shift_q <= bus.cmd_shift;
          cnt     <= '0;
          state   <= CLR;
        end
        CLR:    state <= (len_q != '0) ? MAC : DRAIN0;
        MAC: if (bus.op_valid) begin
          cnt <= cnt + LEN_BITWIDTH'(1);
          if (last_mac) state <= DRAIN0;
        end
        DRAIN0: state <= DRAIN1;
        DRAIN1: state <= RND;
        RND:    state <= OUT;
        OUT:    state <= WAIT0;
        WAIT0:  state <= WAIT1;
        WAIT1: begin
          bus.res_data <= bus.pe_result;
          state        <= RESP;
        end
        RESP:   if (bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers: loaded on the MAC handshake, so the PE sees them the
  // cycle after the matching MAC instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pe_vector <= '0;
      bus.pe_matrix <= '0;
    end else if (op_fire) begin
      bus.pe_vector <= bus.op_vector;
      bus.pe_matrix <= bus.op_matrix;
    end
  end

  // Handshake flags and PE instruction decoded from the state register.
  always_comb begin
    bus.cmd_ready     = (state == IDLE);
    bus.op_ready      = (state == MAC);
    bus.busy          = (state != IDLE);
    bus.res_valid     = (state == RESP);
    bus.pe_inst_valid = 1'b0;
    bus.pe_inst       = '0;
    case (state)
      CLR: begin
        bus.pe_inst_valid  = 1'b1;
        bus.pe_inst.opcode = ~`PE_RND_OPCODE;
        bus.pe_inst.value  = `PE_CLR_VALUE;
        bus.pe_inst.mode   = mode_q;
      end
      MAC: begin
        bus.pe_inst_valid  = bus.op_valid;
        bus.pe_inst.opcode = ~`PE_RND_OPCODE;
        bus.pe_inst.value  = `PE_MAC_VALUE;
        bus.pe_inst.mode   = mode_q;
      end
      RND: begin
        bus.pe_inst_valid  = 1'b1;
        bus.pe_inst.opcode = `PE_RND_OPCODE;
        bus.pe_inst.value  = shift_q;
        bus.pe_inst.mode   = mode_q;
      end
      OUT: begin
        bus.pe_inst_valid  = 1'b1;
        bus.pe_inst.opcode = ~`PE_RND_OPCODE;
        bus.pe_inst.value  = `PE_OUT_VALUE;
        bus.pe_inst.mode   = mode_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: a lane-SIMD PE model closes the loop, fixed vectors
// and random commands are checked against a sum-of-products reference.
module tb_pe_sequencer;
  localparam int LB = 4;
  localparam logic       RND_OP = 1'b1;
  localparam logic [4:0] CLR_V  = 5'd0;
  localparam logic [4:0] MAC_V  = 5'd1;
  localparam logic [4:0] OUT_V  = 5'd2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_sequencer_if #(.LEN_BITWIDTH(LB)) bus ();
  pe_sequencer #(.LEN_BITWIDTH(LB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  mode;
    int          n;
    logic [4:0]  sh;
    logic [31:0] v[4];
    logic [31:0] m[4];
    int          st_after;
    int          st_len;
    int          rr;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic [31:0] opv[16];
  logic [31:0] opm[16];
  logic [31:0] pv_m, pm_m;
  logic        rec_v[64];
  logic        rec_o[64];
  logic [4:0]  rec_val[64];
  logic [1:0]  rec_m[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lw(input logic [1:0] mode);
    return (mode == 2'd0) ? 8 : (mode == 2'd1) ? 16 : 32;
  endfunction

  function automatic longint sx(input logic [63:0] x, input int w);
    logic [63:0] y;
    y = x << (64 - w);
    return $signed(y) >>> (64 - w);
  endfunction

  // Reference: per lane, whole sum of signed products, wrapped to lane width,
  // then arithmetic right shift.
  function automatic logic [31:0] ref_res(input logic [1:0] mode, input int n, input logic [4:0] sh);
    int w;
    logic [31:0] r;
    w = lw(mode);
    r = '0;
    for (int l = 0; l < 32 / w; l++) begin
      longint sum;
      sum = 0;
      for (int k = 0; k < n; k++)
        sum += sx(64'(opv[k] >> (l * w)), w) * sx(64'(opm[k] >> (l * w)), w);
      sum = sx(sum, w) >>> sh;
      for (int b = 0; b < w; b++) r[l * w + b] = sum[b];
    end
    return r;
  endfunction

  // PE model: executes an instruction the cycle after it is issued.
  logic       stg_v, stg_o;
  logic [4:0] stg_val;
  logic [1:0] stg_m;
  logic [31:0] acc;

  function automatic logic [31:0] pe_step(input logic [31:0] a, input logic [31:0] v,
                                          input logic [31:0] m, input logic [1:0] mode,
                                          input logic rnd, input logic [4:0] sh);
    int w;
    logic [31:0] r;
    longint x;
    w = lw(mode);
    r = '0;
    for (int l = 0; l < 32 / w; l++) begin
      if (rnd) x = sx(64'(a >> (l * w)), w) >>> sh;
      else     x = sx(64'(a >> (l * w)), w) + sx(64'(v >> (l * w)), w) * sx(64'(m >> (l * w)), w);
      for (int b = 0; b < w; b++) r[l * w + b] = x[b];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v <= 1'b0; stg_o <= 1'b0; stg_val <= '0; stg_m <= '0;
      acc <= '0; bus.pe_result <= '0;
    end else begin
      stg_v   <= bus.pe_inst_valid;
      stg_o   <= bus.pe_inst.opcode;
      stg_val <= bus.pe_inst.value;
      stg_m   <= bus.pe_inst.mode;
      if (stg_v) begin
        if (stg_o == RND_OP)       acc <= pe_step(acc, '0, '0, stg_m, 1'b1, stg_val);
        else if (stg_val == CLR_V) acc <= '0;
        else if (stg_val == MAC_V) acc <= pe_step(acc, bus.pe_vector, bus.pe_matrix, stg_m, 1'b0, 5'd0);
        else if (stg_val == OUT_V) bus.pe_result <= acc;
      end
    end
  end

  task automatic run_cmd(input string tag, input logic [1:0] mode, input int n, input logic [4:0] sh,
                         input int st_after, input int st_len, input int rr,
                         input logic [31:0] exp_res, input int exp_lat);
    int t, idx, stalled, lat;
    bit bub_bad, opr_seen, issue_bad, pv_bad;
    logic [31:0] res;
    t = 0; idx = 0; stalled = 0; lat = -1;
    bub_bad = 0; opr_seen = 0; issue_bad = 0; pv_bad = 0;
    for (int i = 0; i < 64; i++) begin rec_v[i] = 0; rec_o[i] = 0; rec_val[i] = '0; rec_m[i] = '0; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_len = LB'(n); bus.cmd_shift = sh;
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    chk({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    while (lat < 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
      // command lines wiggle while busy; they must be ignored
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_mode  = 2'($urandom_range(0, 3));
      bus.cmd_len   = LB'($urandom);
      bus.cmd_shift = 5'($urandom);
      if (bus.op_ready && idx == st_after && stalled < st_len) begin
        bus.op_valid = 1'b0; stalled++;
      end else if (bus.op_ready) begin
        bus.op_valid = 1'b1; bus.op_vector = opv[idx % 16]; bus.op_matrix = opm[idx % 16];
      end else begin
        bus.op_valid = 1'($urandom_range(0, 1)); bus.op_vector = $urandom; bus.op_matrix = $urandom;
      end
      @(negedge clk);
      if (t < 64) begin
        rec_v[t] = bus.pe_inst_valid; rec_o[t] = bus.pe_inst.opcode;
        rec_val[t] = bus.pe_inst.value; rec_m[t] = bus.pe_inst.mode;
      end
      if (bus.pe_vector !== pv_m || bus.pe_matrix !== pm_m) pv_bad = 1;
      if (bus.op_ready) opr_seen = 1;
      if (bus.op_ready && bus.op_valid) begin
        if (!bus.pe_inst_valid || bus.pe_inst.opcode != ~RND_OP || bus.pe_inst.value != MAC_V ||
            bus.pe_inst.mode != mode) issue_bad = 1;
        pv_m = opv[idx % 16]; pm_m = opm[idx % 16];
        idx++;
      end
      if (bus.op_ready && !bus.op_valid && bus.pe_inst_valid) bub_bad = 1;
      if (bus.res_valid) lat = t;
    end
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    res = bus.res_data;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " res_data"}, 64'(res), 64'(exp_res));
    chk({tag, " mac count"}, 64'(idx), 64'(n));
    chk({tag, " mac issue"}, 64'(issue_bad), 64'd0);
    chk({tag, " bubble"}, 64'(bub_bad), 64'd0);
    chk({tag, " operand regs"}, 64'(pv_bad), 64'd0);
    if (n == 0) chk({tag, " op_ready idle"}, 64'(opr_seen), 64'd0);
    chk({tag, " CLR inst"}, {rec_v[1], rec_o[1], rec_val[1], rec_m[1]}, {1'b1, ~RND_OP, CLR_V, mode});
    if (exp_lat >= 5 && exp_lat < 64) begin
      chk({tag, " RND inst"}, {rec_v[exp_lat-4], rec_o[exp_lat-4], rec_val[exp_lat-4], rec_m[exp_lat-4]},
          {1'b1, RND_OP, sh, mode});
      chk({tag, " OUT inst"}, {rec_v[exp_lat-3], rec_o[exp_lat-3], rec_val[exp_lat-3], rec_m[exp_lat-3]},
          {1'b1, ~RND_OP, OUT_V, mode});
    end
    for (int d = 0; d < rr; d++) begin
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk({tag, " resp hold"}, {bus.res_valid, bus.cmd_ready, bus.res_data}, {1'b1, 1'b0, exp_res});
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk({tag, " res_valid at handshake"}, 64'(bus.res_valid), 64'd1);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk({tag, " back to idle"}, {bus.cmd_ready, bus.res_valid, bus.busy}, {1'b1, 1'b0, 1'b0});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " reset outs"},
        {bus.cmd_ready, bus.op_ready, bus.pe_inst_valid, bus.res_valid, bus.busy},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk({tag, " reset inst"}, 64'(bus.pe_inst), 64'd0);
    chk({tag, " reset data"}, {bus.pe_vector, bus.pe_matrix}, 64'd0);
    chk({tag, " reset res_data"}, 64'(bus.res_data), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_len = 0; bus.cmd_shift = 0;
    bus.op_valid = 0; bus.op_vector = 0; bus.op_matrix = 0; bus.res_ready = 0;
    pv_m = '0; pm_m = '0;

    // fixed vectors: mode, n, shift, ops, stall, res_ready delay, result, latency
    e.mode = 2; e.n = 2; e.sh = 1; e.v = '{3, -5, 0, 0}; e.m = '{4, 6, 0, 0};
    e.st_after = 0; e.st_len = 0; e.rr = 0; e.exp = 32'hFFFF_FFF7; e.lat = 10; tbl[0] = e;
    e.mode = 0; e.n = 1; e.sh = 0; e.v = '{32'h0403_0201, 0, 0, 0}; e.m = '{32'h0202_0202, 0, 0, 0};
    e.exp = 32'h0806_0402; e.lat = 9; tbl[1] = e;
    e.mode = 1; e.n = 0; e.sh = 3; e.rr = 2; e.exp = 0; e.lat = 8; tbl[2] = e;
    e.mode = 2; e.n = 3; e.sh = 0; e.v = '{1, 3, 5, 0}; e.m = '{2, 4, 6, 0};
    e.rr = 0; e.exp = 32'h2C; e.lat = 11; tbl[3] = e;
    e.st_after = 1; e.st_len = 3; e.lat = 14; tbl[4] = e;
    e.mode = 3; e.n = 2; e.sh = 1; e.v = '{3, -5, 0, 0}; e.m = '{4, 6, 0, 0};
    e.st_after = 0; e.st_len = 0; e.rr = 5; e.exp = 32'hFFFF_FFF7; e.lat = 10; tbl[5] = e;
    e.mode = 2; e.n = 15; e.sh = 0; e.v = '{1, 1, 1, 1}; e.m = '{1, 1, 1, 1};
    e.rr = 0; e.exp = 32'hF; e.lat = 23; tbl[6] = e;
    e.mode = 1; e.n = 2; e.sh = 2; e.v = '{32'h7FFF_8000, 32'h0001_0002, 0, 0};
    e.m = '{32'h0002_0002, 32'h0003_0003, 0, 0}; e.exp = 32'h0000_0001; e.lat = 10; tbl[7] = e;

    @(negedge clk);
    chk_reset_outs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) begin opv[k] = tbl[i].v[k % 4]; opm[k] = tbl[i].m[k % 4]; end
      run_cmd($sformatf("vec%0d", i), tbl[i].mode, tbl[i].n, tbl[i].sh, tbl[i].st_after,
              tbl[i].st_len, tbl[i].rr, tbl[i].exp, tbl[i].lat);
    end

    // reset in the middle of MAC, checked before any clock edge
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.cmd_mode = 2; bus.cmd_len = 5; bus.cmd_shift = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 0; bus.op_valid = 1; bus.op_vector = 32'h1234; bus.op_matrix = 32'h5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midmac");
    bus.op_valid = 0;
    pv_m = '0; pm_m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin opv[k] = tbl[0].v[k % 4]; opm[k] = tbl[0].m[k % 4]; end
    run_cmd("after_reset", tbl[0].mode, tbl[0].n, tbl[0].sh, 0, 0, 0, tbl[0].exp, tbl[0].lat);

    // random commands against the reference
    for (int r = 0; r < 10; r++) begin
      logic [1:0] mode;
      logic [4:0] sh;
      int n, sa, sl, rr, lat;
      mode = 2'($urandom_range(0, 3));
      n    = $urandom_range(0, 7);
      sh   = 5'($urandom_range(0, 31));
      sa   = $urandom_range(0, 7);
      sl   = $urandom_range(0, 3);
      rr   = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++) begin opv[k] = $urandom; opm[k] = $urandom; end
      lat = n + 8 + ((sa < n) ? sl : 0);
      run_cmd($sformatf("rnd%0d", r), mode, n, sh, sa, sl, rr, ref_res(mode, n, sh), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
